// File: rtl/csr_access_unit_pkg.sv
// Shared encodings for the Zicsr requester: funct3 codes, FSM states, CSR map.
package csr_access_unit_pkg;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRead  = 3'd1,
    StCsrWr = 3'd2,
    StRdWr  = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;

  // Idle value of the CSR address buses (no access).
  localparam logic [11:0] MDISABLE = 12'h000;
  localparam logic [4:0]  ZERO_REG = 5'd0;

  function automatic logic csr_supported(input logic [11:0] addr);
    case (addr)
      CSR_MSTATUS, CSR_MISA, CSR_MTVEC, CSR_MSCRATCH,
      CSR_MEPC, CSR_MCYCLE, CSR_MCYCLEH, CSR_MVENDORID: csr_supported = 1'b1;
      default:                                          csr_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/csr_access_unit_alu.sv
// Read-modify step of a Zicsr instruction: new CSR value and write enable.
module csr_alu
  import csr_access_unit_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [2:0]            funct3,
  input  logic [DATA_W-1:0]     old_val,
  input  logic [DATA_W-1:0]     src,
  input  logic [REG_ADDR_W-1:0] src_idx,
  output logic [DATA_W-1:0]     new_val,
  output logic                  wr_en
);

  // I forms share the register-form behaviour; funct3[2] only selects the source upstream.
  always_comb begin
    new_val = old_val;
    wr_en   = 1'b0;
    case (funct3[1:0])
      2'b01: begin
        new_val = src;
        wr_en   = 1'b1;
      end
      2'b10: begin
        new_val = old_val | src;
        wr_en   = (src_idx != '0);
      end
      2'b11: begin
        new_val = old_val & ~src;
        wr_en   = (src_idx != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr requester: read -> modify -> CSR write -> rd write -> done, fixed 5-cycle cadence.
module csr_access_unit
  import csr_access_unit_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CSR_ADDR_W = 12,
  parameter int unsigned REG_ADDR_W = 5,
  parameter logic [CSR_ADDR_W-1:0] CSR_NONE = CSR_ADDR_W'(MDISABLE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_funct3,
  input  logic [CSR_ADDR_W-1:0] req_csr,
  input  logic [DATA_W-1:0]     req_src,
  input  logic [REG_ADDR_W-1:0] req_src_idx,
  input  logic [REG_ADDR_W-1:0] req_rd,
  output logic [CSR_ADDR_W-1:0] csr_raddr,
  input  logic [DATA_W-1:0]     csr_rdata,
  output logic [CSR_ADDR_W-1:0] csr_waddr,
  output logic [DATA_W-1:0]     csr_wdata,
  output logic [REG_ADDR_W-1:0] rd_waddr,
  output logic [DATA_W-1:0]     rd_wdata,
  output logic                  done,
  output logic                  illegal
);

  state_e                state_q, state_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [CSR_ADDR_W-1:0] csr_q, csr_d;
  logic [DATA_W-1:0]     src_q, src_d;
  logic [REG_ADDR_W-1:0] src_idx_q, src_idx_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0]     old_q, old_d;
  logic                  bad_q, bad_d;

  logic [CSR_ADDR_W-1:0] csr_raddr_d, csr_waddr_d;
  logic [DATA_W-1:0]     csr_wdata_d, rd_wdata_d;
  logic [REG_ADDR_W-1:0] rd_waddr_d;
  logic                  done_d, illegal_d;

  logic [DATA_W-1:0]     alu_new;
  logic                  alu_wen;
  logic                  is_bad;

  csr_alu #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_alu (
    .funct3  (funct3_q),
    .old_val (csr_rdata),
    .src     (src_q),
    .src_idx (src_idx_q),
    .new_val (alu_new),
    .wr_en   (alu_wen)
  );

  assign req_ready = (state_q == StIdle);

  // Illegal: reserved funct3, unmapped CSR, or a write to the read-only space.
  assign is_bad = (funct3_q[1:0] == 2'b00) || !csr_supported(12'(csr_q)) ||
                  (alu_wen && (csr_q[CSR_ADDR_W-1 -: 2] == 2'b11));

  // Next state, request latches and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    csr_d       = csr_q;
    src_d       = src_q;
    src_idx_d   = src_idx_q;
    rd_d        = rd_q;
    old_d       = old_q;
    bad_d       = bad_q;
    csr_raddr_d = CSR_NONE;
    csr_waddr_d = CSR_NONE;
    csr_wdata_d = '0;
    rd_waddr_d  = '0;
    rd_wdata_d  = '0;
    done_d      = 1'b0;
    illegal_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          funct3_d    = req_funct3;
          csr_d       = req_csr;
          src_d       = req_src;
          src_idx_d   = req_src_idx;
          rd_d        = req_rd;
          csr_raddr_d = req_csr;
          state_d     = StRead;
        end
      end
      StRead: begin
        old_d = csr_rdata;
        bad_d = is_bad;
        if (alu_wen && !is_bad) begin
          csr_waddr_d = csr_q;
          csr_wdata_d = alu_new;
        end
        state_d = StCsrWr;
      end
      StCsrWr: begin
        if (!bad_q && (rd_q != REG_ADDR_W'(ZERO_REG))) begin
          rd_waddr_d = rd_q;
          rd_wdata_d = old_q;
        end
        state_d = StRdWr;
      end
      StRdWr: begin
        done_d    = 1'b1;
        illegal_d = bad_q;
        state_d   = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State, latches and registered outputs; reset drops any in-flight instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      funct3_q  <= '0;
      csr_q     <= CSR_NONE;
      src_q     <= '0;
      src_idx_q <= '0;
      rd_q      <= '0;
      old_q     <= '0;
      bad_q     <= 1'b0;
      csr_raddr <= CSR_NONE;
      csr_waddr <= CSR_NONE;
      csr_wdata <= '0;
      rd_waddr  <= '0;
      rd_wdata  <= '0;
      done      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      csr_q     <= csr_d;
      src_q     <= src_d;
      src_idx_q <= src_idx_d;
      rd_q      <= rd_d;
      old_q     <= old_d;
      bad_q     <= bad_d;
      csr_raddr <= csr_raddr_d;
      csr_waddr <= csr_waddr_d;
      csr_wdata <= csr_wdata_d;
      rd_waddr  <= rd_waddr_d;
      rd_wdata  <= rd_wdata_d;
      done      <= done_d;
      illegal   <= illegal_d;
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed bench for csr_access_unit with a small CSR file model.
module tb_csr_access_unit;

  localparam logic [11:0] NONE      = 12'h000;
  localparam logic [11:0] MSTATUS   = 12'h300;
  localparam logic [11:0] MTVEC     = 12'h305;
  localparam logic [11:0] MSCRATCH  = 12'h340;
  localparam logic [11:0] MEPC      = 12'h341;
  localparam logic [11:0] MVENDORID = 12'hF11;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = '0;
  logic [11:0] req_csr = '0;
  logic [31:0] req_src = '0;
  logic [4:0]  req_src_idx = '0;
  logic [4:0]  req_rd = '0;
  logic [11:0] csr_raddr, csr_waddr;
  logic [31:0] csr_rdata, csr_wdata, rd_wdata;
  logic [4:0]  rd_waddr;
  logic        done, illegal;

  int unsigned total = 0;
  int unsigned passed = 0;

  logic [31:0] csr_mem [0:4095];

  always #5 clk = ~clk;

  csr_access_unit dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_funct3  (req_funct3),
    .req_csr     (req_csr),
    .req_src     (req_src),
    .req_src_idx (req_src_idx),
    .req_rd      (req_rd),
    .csr_raddr   (csr_raddr),
    .csr_rdata   (csr_rdata),
    .csr_waddr   (csr_waddr),
    .csr_wdata   (csr_wdata),
    .rd_waddr    (rd_waddr),
    .rd_wdata    (rd_wdata),
    .done        (done),
    .illegal     (illegal)
  );

  assign csr_rdata = csr_mem[csr_raddr];

  // CSR file model: a write is dropped if an rd write shares the cycle.
  always @(posedge clk) begin
    if (csr_waddr != NONE && rd_waddr == 5'd0) csr_mem[csr_waddr] <= csr_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  // CSR and rd writes must never overlap.
  always @(negedge clk) begin
    chk("no_overlap", 32'((csr_waddr != NONE) && (rd_waddr != 5'd0)), 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request and take the accept edge; leaves valid high, inputs scrambled.
  task automatic accept(input logic [2:0] f3, input logic [11:0] csr, input logic [31:0] src,
                        input logic [4:0] idx, input logic [4:0] rd);
    req_funct3  = f3;
    req_csr     = csr;
    req_src     = src;
    req_src_idx = idx;
    req_rd      = rd;
    req_valid   = 1'b1;
    tick();
    req_funct3  = 3'b000;
    req_csr     = 12'hABC;
    req_src     = 32'h5A5A5A5A;
    req_src_idx = 5'd0;
    req_rd      = 5'd0;
  endtask

  // Walk READ..IDLE from the cycle after the accept edge.
  task automatic follow(input string tag, input logic [11:0] csr, input logic wen,
                        input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] old,
                        input logic ill);
    chk({tag, ".read_raddr"}, 32'(csr_raddr), 32'(csr));
    chk({tag, ".read_ready"}, 32'(req_ready), 32'd0);
    tick();
    chk({tag, ".wr_waddr"}, 32'(csr_waddr), 32'(wen ? csr : NONE));
    chk({tag, ".wr_wdata"}, csr_wdata, wen ? wdata : 32'd0);
    chk({tag, ".wr_raddr"}, 32'(csr_raddr), 32'(NONE));
    tick();
    chk({tag, ".rd_waddr"}, 32'(rd_waddr), 32'(rd));
    chk({tag, ".rd_wdata"}, rd_wdata, (rd != 5'd0) ? old : 32'd0);
    chk({tag, ".rd_csrw"}, 32'(csr_waddr), 32'(NONE));
    tick();
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".illegal"}, 32'(illegal), 32'(ill));
    chk({tag, ".done_rdw"}, 32'(rd_waddr), 32'd0);
    tick();
    chk({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) csr_mem[i] = '0;
    csr_mem[MSTATUS]   = 32'h8;
    csr_mem[MVENDORID] = 32'h013109F5;

    // Reset state
    #2;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_raddr", 32'(csr_raddr), 32'(NONE));
    chk("rst_waddr", 32'(csr_waddr), 32'(NONE));
    chk("rst_rdaddr", 32'(rd_waddr), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // 1. CSRRW mscratch
    accept(3'b001, MSCRATCH, 32'hDEADBEEF, 5'd1, 5'd5);
    req_valid = 1'b0;
    follow("t1_rw", MSCRATCH, 1'b1, 32'hDEADBEEF, 5'd5, 32'h0, 1'b0);
    chk("t1_mem", csr_mem[MSCRATCH], 32'hDEADBEEF);

    // 2. CSRRS then CSRRC on mstatus
    accept(3'b010, MSTATUS, 32'h80, 5'd3, 5'd1);
    req_valid = 1'b0;
    follow("t2_rs", MSTATUS, 1'b1, 32'h88, 5'd1, 32'h8, 1'b0);
    accept(3'b011, MSTATUS, 32'h8, 5'd2, 5'd6);
    req_valid = 1'b0;
    follow("t2_rc", MSTATUS, 1'b1, 32'h80, 5'd6, 32'h88, 1'b0);

    // 3. mvendorid: read-only set with src_idx=0 is fine, with src_idx=1 is illegal
    accept(3'b010, MVENDORID, 32'h0, 5'd0, 5'd7);
    req_valid = 1'b0;
    follow("t3_ro_rd", MVENDORID, 1'b0, 32'h0, 5'd7, 32'h013109F5, 1'b0);
    accept(3'b010, MVENDORID, 32'h1, 5'd1, 5'd7);
    req_valid = 1'b0;
    follow("t3_ro_wr", MVENDORID, 1'b0, 32'h0, 5'd0, 32'h0, 1'b1);

    // 4. Reserved funct3 and unmapped CSR
    accept(3'b100, MSCRATCH, 32'h1, 5'd1, 5'd3);
    req_valid = 1'b0;
    follow("t4_f3_100", MSCRATCH, 1'b0, 32'h0, 5'd0, 32'h0, 1'b1);
    accept(3'b001, 12'h7C0, 32'h1, 5'd1, 5'd3);
    req_valid = 1'b0;
    follow("t4_unmapped", 12'h7C0, 1'b0, 32'h0, 5'd0, 32'h0, 1'b1);

    // Immediate forms: RWI always writes; RSI with zimm=0 and rd=0 writes nothing
    accept(3'b101, MTVEC, 32'h1F, 5'd31, 5'd4);
    req_valid = 1'b0;
    follow("rwi_mtvec", MTVEC, 1'b1, 32'h1F, 5'd4, 32'h0, 1'b0);
    accept(3'b110, MEPC, 32'h0, 5'd0, 5'd0);
    req_valid = 1'b0;
    follow("rsi_nop", MEPC, 1'b0, 32'h0, 5'd0, 32'h0, 1'b0);

    // 5. Reset during CSR_WR of a CSRRW
    accept(3'b001, MEPC, 32'h1234, 5'd1, 5'd9);
    req_valid = 1'b0;
    tick();
    chk("t5_pre_waddr", 32'(csr_waddr), 32'(MEPC));
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_waddr", 32'(csr_waddr), 32'(NONE));
    chk("t5_rst_wdata", csr_wdata, 32'd0);
    chk("t5_rst_ready", 32'(req_ready), 32'd1);
    tick();
    rst = 1'b0;
    chk("t5_rel_ready", 32'(req_ready), 32'd1);
    tick();
    chk("t5_rel_rdaddr", 32'(rd_waddr), 32'd0);
    chk("t5_rel_raddr", 32'(csr_raddr), 32'(NONE));
    tick();
    chk("t5_no_done", 32'(done), 32'd0);
    chk("t5_no_rdw", 32'(rd_waddr), 32'd0);

    // 6. Back-to-back CSRRWI with req_valid held high
    accept(3'b101, MSCRATCH, 32'h5, 5'd5, 5'd10);
    req_funct3  = 3'b101;
    req_csr     = MTVEC;
    req_src     = 32'hA;
    req_src_idx = 5'd10;
    req_rd      = 5'd11;
    follow("t6_first", MSCRATCH, 1'b1, 32'h5, 5'd10, 32'hDEADBEEF, 1'b0);
    tick();
    req_valid = 1'b0;
    follow("t6_second", MTVEC, 1'b1, 32'hA, 5'd11, 32'h1F, 1'b0);
    chk("t6_mem_mscratch", csr_mem[MSCRATCH], 32'h5);
    chk("t6_mem_mtvec", csr_mem[MTVEC], 32'hA);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
